// File: rtl/l2_pkg.sv
// Shared types and default constants for the L2 input feeder slice.
package l2_pkg;

  localparam int L2_DATA_W    = 8;
  localparam int L2_DEPTH     = 4;
  // 16 * 255^2 = 1,040,400 still fits the 20-bit downstream accumulator.
  localparam int L2_MAX_LEN   = 16;
  // Matches the latency of the downstream square/accumulate pipe.
  localparam int L2_DRAIN_CYC = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DRAIN   = 2'd3
  } feed_state_t;

  // One queued element: the last flag rides alongside the byte.
  typedef struct packed {
    logic                 last;
    logic [L2_DATA_W-1:0] data;
  } feed_entry_t;

  localparam int L2_ENTRY_W = $bits(feed_entry_t);

endpackage

// File: rtl/l2_byte_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a fall-through read port.
module l2_byte_fifo
  import l2_pkg::*;
#(
  parameter int WIDTH = L2_ENTRY_W,
  parameter int DEPTH = L2_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates "full" from "empty" when the
  // index bits coincide.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // A full FIFO refuses the write even if a pop frees a slot this cycle.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Advance pointers on accepted writes and reads; wrap is natural modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; the pointers alone decide
    // which slots hold live data, and resetting RAM would block inference.
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/l2_input_feeder.sv
// Buffers incoming vector elements and issues them one per cycle to the
// squaring/accumulating stage, enforcing a maximum vector length and
// idling for the downstream pipe depth after each vector.
module l2_input_feeder
  import l2_pkg::*;
#(
  parameter int DEPTH     = L2_DEPTH,
  parameter int MAX_LEN   = L2_MAX_LEN,
  parameter int DRAIN_CYC = L2_DRAIN_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] a,
  output logic       valid_in,
  output logic       vec_last,
  output logic       vec_done,
  output logic       len_err
);

  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam int DRN_W = $clog2(DRAIN_CYC) + 1;

  // Index of the final element a vector may legally issue (0-based).
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MAX_LEN - 1);
  localparam logic [DRN_W-1:0] DRAIN_END = DRN_W'(DRAIN_CYC - 1);

  feed_state_t            state;
  logic [CNT_W-1:0]       elem_cnt;
  logic [DRN_W-1:0]       drain_cnt;

  feed_entry_t            wr_entry;
  feed_entry_t            rd_entry;
  logic [L2_ENTRY_W-1:0]  wr_bits;
  logic [L2_ENTRY_W-1:0]  rd_bits;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign wr_entry = '{last: in_last, data: in_data};
  assign wr_bits  = wr_entry;
  assign rd_entry = feed_entry_t'(rd_bits);

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  // Pop whenever the FSM is consuming entries (issuing or discarding).
  always_comb begin
    // NOTE: default first so every path assigns pop and no latch is inferred.
    pop = 1'b0;
    case (state)
      ST_IDLE, ST_STREAM, ST_DISCARD: pop = !empty;
      default:                        pop = 1'b0;
    endcase
  end

  l2_byte_fifo #(
    .WIDTH (L2_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_bits),
    .rd_en   (pop),
    .rd_data (rd_bits),
    .full    (full),
    .empty   (empty)
  );

  // Feeder FSM with registered issue outputs, length counter and drain timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      elem_cnt  <= '0;
      drain_cnt <= '0;
      a         <= '0;
      valid_in  <= 1'b0;
      vec_last  <= 1'b0;
      vec_done  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      valid_in <= 1'b0;
      vec_last <= 1'b0;
      vec_done <= 1'b0;

      case (state)
        ST_IDLE, ST_STREAM: begin
          // With nothing queued, a keeps its previous value.
          if (!empty) begin
            a        <= rd_entry.data;
            valid_in <= 1'b1;
            elem_cnt <= elem_cnt + 1'b1;
            if (rd_entry.last) begin
              vec_last  <= 1'b1;
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end else if (elem_cnt == LAST_IDX) begin
              // Overlong vector: close it here and throw away the rest.
              vec_last <= 1'b1;
              len_err  <= 1'b1;
              state    <= ST_DISCARD;
            end else begin
              state <= ST_STREAM;
            end
          end
        end

        ST_DISCARD: begin
          if (!empty && rd_entry.last) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            vec_done <= 1'b1;
            elem_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_input_feeder.sv
// Self-checking bench for l2_input_feeder: directed scenarios plus random
// vectors scored against a transaction-level model of the issue stream.
module tb_l2_input_feeder;

  localparam int MAX_LEN   = 16;
  localparam int DRAIN_CYC = 3;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] a;
  logic       valid_in;
  logic       vec_last;
  logic       vec_done;
  logic       len_err;

  l2_input_feeder #(
    .DEPTH     (4),
    .MAX_LEN   (MAX_LEN),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .a        (a),
    .valid_in (valid_in),
    .vec_last (vec_last),
    .vec_done (vec_done),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       forced;
  } exp_t;

  exp_t exp_q[$];
  int   cur_len     = 0;
  bit   discarding  = 0;
  bit   m_len_err   = 0;
  bit   waiting     = 0;
  bit   forced_wait = 0;
  int   since_last  = 0;
  int   issued_cnt  = 0;
  int   done_cnt    = 0;

  // Turn one accepted input element into the issue the feeder should make.
  function automatic void model_accept(input logic [7:0] d, input logic l);
    exp_t e;
    if (discarding) begin
      if (l) discarding = 0;
    end else begin
      cur_len++;
      e.d = d;
      if (l) begin
        e.last = 1'b1; e.forced = 1'b0; cur_len = 0;
      end else if (cur_len == MAX_LEN) begin
        e.last = 1'b1; e.forced = 1'b1; cur_len = 0;
        discarding = 1; m_len_err = 1;
      end else begin
        e.last = 1'b0; e.forced = 1'b0;
      end
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: records accepted inputs and scores every output cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      cur_len = 0; discarding = 0; m_len_err = 0;
      waiting = 0; forced_wait = 0; since_last = 0;
    end else begin
      if (in_valid && in_ready) model_accept(in_data, in_last);
      if (waiting) begin
        since_last++;
        check("drain_quiet", valid_in, 0);
      end
      if (valid_in) begin
        issued_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_issue", valid_in, 0);
        end else begin
          e = exp_q.pop_front();
          check("issue_data", a, e.d);
          check("issue_last", vec_last, e.last);
          if (e.forced) check("len_err_on_force", len_err, 1);
          if (e.last) begin
            waiting = 1; since_last = 0; forced_wait = e.forced;
          end
        end
      end
      if (vec_done) begin
        done_cnt++;
        if (!waiting) begin
          check("spurious_done", vec_done, 0);
        end else begin
          if (!forced_wait) check("done_latency", since_last, DRAIN_CYC);
          else              check("done_after_discard", since_last > DRAIN_CYC, 1);
          waiting = 0;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Present one element from just after a rising edge until it is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int tries;
    tries    = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      tries++;
      if (tries > 200) begin
        check("send_timeout", in_ready, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until every expected issue and drain has been observed.
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || waiting) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, n < 400, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int iss0, done0, n, len;
    logic [7:0] rd;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a", a, 0);
    check("rst_valid_in", valid_in, 0);
    check("rst_vec_last", vec_last, 0);
    check("rst_vec_done", vec_done, 0);
    check("rst_len_err", len_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Two-element vector 3,4 with exact timing
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'd3; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 8'd4; in_last = 1'b1;
    @(negedge clk);
    check("v34_not_yet", valid_in, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("v34_valid0", valid_in, 1);
    check("v34_a0", a, 3);
    check("v34_last0", vec_last, 0);
    @(negedge clk);
    check("v34_valid1", valid_in, 1);
    check("v34_a1", a, 4);
    check("v34_last1", vec_last, 1);
    @(negedge clk);
    check("v34_idle1", valid_in, 0);
    check("v34_done_early1", vec_done, 0);
    @(negedge clk);
    check("v34_done_early2", vec_done, 0);
    @(negedge clk);
    check("v34_done", vec_done, 1);
    check("v34_a_hold", a, 4);
    @(negedge clk);
    check("v34_done_pulse", vec_done, 0);
    check("v34_len_err", len_err, 0);
    @(posedge clk); #1;

    // Overlong vector: 17 x 255, then a single-element vector
    iss0 = issued_cnt; done0 = done_cnt;
    for (int i = 0; i < 17; i++) send(8'd255, i == 16);
    send(8'd1, 1'b1);
    wait_drain("overlong");
    check("overlong_issued", issued_cnt - iss0, 17);
    check("overlong_dones", done_cnt - done0, 2);
    check("overlong_len_err", len_err, 1);

    // Fill during a drain: in_ready drops after 4 stored entries
    send(8'd20, 1'b1);
    for (int i = 0; i < 4; i++) send(8'(30 + i), 1'b0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    send(8'd34, 1'b0);
    send(8'd35, 1'b1);
    wait_drain("fill");
    check("fill_in_ready_back", in_ready, 1);

    // Back-to-back single-element vectors 5 then 7
    done0 = done_cnt;
    send(8'd5, 1'b1);
    send(8'd7, 1'b1);
    wait_drain("b2b");
    check("b2b_dones", done_cnt - done0, 2);
    check("sticky_len_err", len_err, 1);

    // Reset while STREAM holds queued entries
    send(8'd5, 1'b1);
    for (int i = 0; i < 4; i++) send(8'(10 + i), 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid_in && a == 8'd10) && n < 50);
    check("mid_reset_reached", n < 50, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid_in", valid_in, 0);
    check("mid_rst_a", a, 0);
    check("mid_rst_vec_last", vec_last, 0);
    check("mid_rst_vec_done", vec_done, 0);
    check("mid_rst_len_err", len_err, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_quiet", valid_in, 0);
      check("post_rst_no_done", vec_done, 0);
    end
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(8'd9, 1'b1);
    wait_drain("post_rst");

    // Random vectors, including an exact-MAX_LEN one and an overlong one
    for (int v = 0; v < 30; v++) begin
      len = (v == 0) ? MAX_LEN : (v == 5) ? MAX_LEN + 2 : int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) begin
        rd = 8'($urandom_range(0, 255));
        send(rd, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
      end
      if (v == 0) begin
        wait_drain("exact_max");
        check("exact_max_no_err", len_err, 0);
      end
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(0, 4)));
    end
    wait_drain("random");
    check("random_len_err", len_err, 32'(m_len_err));
    check("random_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
